// File: rtl/nanov_alu_pkg.sv
// nanov_alu_pkg: shared types and constants for the nanoV bit-serial ALU.
//   XLEN        operand width in bits
//   alu_op_t    operation codes sampled with start
//   alu_state_t serial sequencer states
//   is_sub()    ops that run the adder as A + ~B + 1
package nanov_alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ADD    = 3'd0,
    SUB    = 3'd1,
    AND    = 3'd2,
    OR     = 3'd3,
    XOR    = 3'd4,
    SLT    = 3'd5,
    SLTU   = 3'd6,
    PASS_B = 3'd7
  } alu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } alu_state_t;

  function automatic logic is_sub(input alu_op_t op);
    return (op == SUB) || (op == SLT) || (op == SLTU);
  endfunction

endpackage

// File: rtl/nanov_serial_addsub.sv
// nanov_serial_addsub: one-bit full adder with optional B inversion and a carry flop.
//   clk, rst   clock / async active-high reset (carry cleared)
//   en         a bit is consumed this cycle: carry flop captures carry_out
//   load       first bit of an operation: carry-in comes from sub, not the flop
//   sub        invert b and force carry-in 1 on the first bit (A + ~B + 1)
//   a, b       operand bits
//   sum        result bit for the current inputs
//   carry_out  carry out of the current bit
module nanov_serial_addsub (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic sub,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry_out
);

  logic carry_q;
  logic cin;
  logic b_eff;

  always_comb begin
    b_eff     = b ^ sub;
    cin       = load ? sub : carry_q;
    sum       = a ^ b_eff ^ cin;
    carry_out = (a & b_eff) | (a & cin) | (b_eff & cin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     carry_q <= 1'b0;
    else if (en) carry_q <= carry_out;
  end

endmodule

// File: rtl/nanov_serial_alu.sv
// nanov_serial_alu: bit-serial integer ALU, operands streamed LSB first.
//   clk, rst     clock / async active-high reset
//   start        begin operation; bit 0 of operands present this cycle
//   op           operation code, sampled with start
//   hold         pause: nothing consumed, no state change
//   data_rs1/2   operand bits
//   data_rd      result bit for the current inputs (zero latency)
//   data_rd_vld  data_rd is a consumed result bit
//   busy         operation in progress after its first bit
//   done         one-cycle pulse after the last bit is consumed
//   cmp_lt       A<B (signed for SLT, unsigned otherwise), held until next done
//   cmp_eq       A==B, held until next done
module nanov_serial_alu
  import nanov_alu_pkg::*;
#(
  parameter int unsigned XLEN = nanov_alu_pkg::XLEN
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    start,
  input  alu_op_t op,
  input  logic    hold,
  input  logic    data_rs1,
  input  logic    data_rs2,
  output logic    data_rd,
  output logic    data_rd_vld,
  output logic    busy,
  output logic    done,
  output logic    cmp_lt,
  output logic    cmp_eq
);

  localparam int unsigned IDX_W = $clog2(XLEN);

  alu_state_t       state_q, state_d;
  alu_op_t          op_q, op_eff;
  logic [IDX_W-1:0] bit_idx_q;
  logic             idle, consume, last_bit, bit_eq, eq_acc_q;
  logic             sum, carry_out, lt_final;

  assign idle     = (state_q == S_IDLE);
  assign consume  = ((start && idle) || !idle) && !hold;
  // Bit 0 is processed in the start cycle, before op reaches the latch.
  assign op_eff   = idle ? op : op_q;
  assign last_bit = (bit_idx_q == IDX_W'(XLEN - 1));
  assign bit_eq   = ~(data_rs1 ^ data_rs2);

  nanov_serial_addsub u_addsub (
    .clk       (clk),
    .rst       (rst),
    .en        (consume),
    .load      (idle),
    .sub       (is_sub(op_eff)),
    .a         (data_rs1),
    .b         (data_rs2),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && !hold)       state_d = S_RUN;
      S_RUN:  if (consume && last_bit)  state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_rd = 1'b0;
    case (op_eff)
      ADD, SUB: data_rd = sum;
      AND:      data_rd = data_rs1 & data_rs2;
      OR:       data_rd = data_rs1 | data_rs2;
      XOR:      data_rd = data_rs1 ^ data_rs2;
      PASS_B:   data_rd = data_rs2;
      default:  data_rd = 1'b0;
    endcase
  end

  // On the sign bit, differing signs decide directly; otherwise the
  // difference sign does. No carry out of A + ~B + 1 means A < B unsigned.
  always_comb begin
    if (op_eff == SLT) lt_final = (data_rs1 ^ data_rs2) ? data_rs1 : sum;
    else               lt_final = !carry_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= ADD;
      bit_idx_q <= '0;
      eq_acc_q  <= 1'b1;
      cmp_lt    <= 1'b0;
      cmp_eq    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= consume && !idle && last_bit;
      if (start && idle && !hold) op_q <= op;
      if (consume) begin
        bit_idx_q <= bit_idx_q + 1'b1;
        if (!idle && last_bit) begin
          cmp_lt   <= lt_final;
          cmp_eq   <= eq_acc_q & bit_eq;
          eq_acc_q <= 1'b1;
        end else begin
          eq_acc_q <= (idle ? 1'b1 : eq_acc_q) & bit_eq;
        end
      end
    end
  end

  assign data_rd_vld = consume;
  assign busy        = !idle;

endmodule

// File: tb/tb_nanov_serial_alu.sv
module tb_nanov_serial_alu;
  import nanov_alu_pkg::*;

  logic    clk = 1'b0;
  logic    rst, start, hold, data_rs1, data_rs2;
  alu_op_t op;
  logic    data_rd, data_rd_vld, busy, done, cmp_lt, cmp_eq;

  always #5 clk = ~clk;

  nanov_serial_alu #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .hold        (hold),
    .data_rs1    (data_rs1),
    .data_rs2    (data_rs2),
    .data_rd     (data_rd),
    .data_rd_vld (data_rd_vld),
    .busy        (busy),
    .done        (done),
    .cmp_lt      (cmp_lt),
    .cmp_eq      (cmp_eq)
  );

  int total = 0;
  int bad   = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic exp_vld, exp_bit, exp_busy, exp_done, exp_lt, exp_eq, lt_chk;
  // Flag results of the op in flight, published in its done cycle.
  logic done_next, pend_lt, pend_eq, pend_lt_chk;

  task automatic check(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, got, want, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input alu_op_t o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      PASS_B:  return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_lt(input alu_op_t o, input logic [31:0] a, input logic [31:0] b);
    if (o == SLT) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  always @(negedge clk) begin
    check("vld", data_rd_vld, exp_vld);
    if (exp_vld) check("rd_bit", data_rd, exp_bit);
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("cmp_eq", cmp_eq, exp_eq);
    if (lt_chk) check("cmp_lt", cmp_lt, exp_lt);
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    exp_done = done_next;
    if (done_next) begin
      exp_eq = pend_eq;
      exp_lt = pend_lt;
      lt_chk = pend_lt_chk;
    end
    done_next = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      start    = 1'b0;
      hold     = 1'($urandom_range(0, 1));
      op       = alu_op_t'($urandom_range(0, 7));
      data_rs1 = 1'($urandom_range(0, 1));
      data_rs2 = 1'($urandom_range(0, 1));
      exp_vld  = 1'b0;
      exp_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  // Streams one operation; hold_bits pauses once before each marked bit.
  // abort_at >= 0 asserts rst when that many bits have been consumed.
  task automatic run_op(input alu_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hold_bits, input int abort_at,
                        output logic [31:0] got);
    logic [31:0] r;
    int          n;
    logic        held;
    r    = model_rd(o, a, b);
    n    = 0;
    held = 1'b0;
    got  = '0;
    while (n < 32) begin
      begin_cycle();
      if (n == abort_at) begin
        rst       = 1'b1;
        start     = 1'b0;
        hold      = 1'b0;
        exp_vld   = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_lt    = 1'b0;
        exp_eq    = 1'b0;
        lt_chk    = 1'b1;
        done_next = 1'b0;
        @(negedge clk);
        begin_cycle();
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      hold     = hold_bits[n] && !held;
      start    = (n == 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
      op       = (n == 0) ? o : alu_op_t'($urandom_range(0, 7));
      data_rs1 = a[n];
      data_rs2 = b[n];
      exp_busy = (n > 0);
      exp_vld  = !hold;
      exp_bit  = r[n];
      @(negedge clk);
      if (!hold) begin
        got[n] = data_rd;
        n++;
        held = 1'b0;
      end else begin
        held = 1'b1;
      end
    end
    done_next   = 1'b1;
    pend_lt     = model_lt(o, a, b);
    pend_eq     = (a == b);
    pend_lt_chk = (o == SUB) || (o == SLT) || (o == SLTU);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got, a, b;
    alu_op_t     o;
    rst = 1'b1; start = 1'b0; hold = 1'b0; op = ADD; data_rs1 = 1'b0; data_rs2 = 1'b0;
    exp_vld = 1'b0; exp_bit = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    exp_lt = 1'b0; exp_eq = 1'b0; lt_chk = 1'b1;
    done_next = 1'b0; pend_lt = 1'b0; pend_eq = 1'b0; pend_lt_chk = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    run_op(ADD, 32'h7FFF_FFFF, 32'h0000_0001, '0, -1, got);
    idle(1);
    check32("add_ovf", got, 32'h8000_0000);
    check("add_eq", cmp_eq, 1'b0);

    run_op(SUB, 32'd5, 32'd7, '0, -1, got);
    idle(1);
    check32("sub_neg", got, 32'hFFFF_FFFE);
    check("sub_lt", cmp_lt, 1'b1);

    run_op(SLT, 32'hFFFF_FFFF, 32'd1, '0, -1, got);
    idle(1);
    check32("slt_rd", got, 32'h0);
    check("slt_lt", cmp_lt, 1'b1);

    run_op(SLTU, 32'hFFFF_FFFF, 32'd1, '0, -1, got);
    idle(1);
    check32("sltu_rd", got, 32'h0);
    check("sltu_lt", cmp_lt, 1'b0);

    run_op(XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, '0, -1, got);
    idle(1);
    check32("xor", got, 32'h5A5A_A5A5);

    run_op(SUB, 32'h1234_5678, 32'h1234_5678, '0, -1, got);
    idle(1);
    check32("sub_eq_rd", got, 32'h0);
    check("sub_eq", cmp_eq, 1'b1);

    run_op(ADD, 32'hFFFF_FFFF, 32'd1, 32'h8000_0018, -1, got);
    idle(1);
    check32("add_hold", got, 32'h0);

    run_op(ADD, 32'hFFFF_FFFF, 32'd1, '0, 17, got);
    check("rst_busy", busy, 1'b0);
    run_op(ADD, 32'd2, 32'd3, '0, -1, got);
    idle(1);
    check32("add_after_rst", got, 32'd5);

    run_op(SUB, 32'h0000_0010, 32'h0000_0020, '0, -1, got);
    run_op(AND, 32'hF0F0_F0F0, 32'hFF00_FF00, '0, -1, got);
    idle(1);
    check32("and_b2b", got, 32'hF000_F000);

    for (int i = 0; i < 60; i++) begin
      o = alu_op_t'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op(o, a, b, ($urandom_range(0, 2) == 0) ? ($urandom & $urandom & $urandom) : '0, -1, got);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
